// File: rtl/lever_pkg.sv
// -----------------------------------------------------------------------------
// lever_pkg
// Shared types and arithmetic for the analog lever emulator.
//   mode_e   : per-channel source select (3 is reserved and treated as HOLD)
//   state_e  : per-channel ramp FSM state
//   dir_e    : decoded D-pad direction
//   sat_step : saturating add/sub clamped to [0, max_val]
// -----------------------------------------------------------------------------
package lever_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SPRING = 2'd1,
        ANALOG = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        FAST   = 2'd2,
        RETURN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Working width for the saturating step; callers narrow the result back
    // to their own WIDTH, which is always well below this.
    localparam int SAT_W = 32;

    // Adds or subtracts step from cur without wrapping: the sum is formed one
    // bit wider than the operands so an overshoot is visible before clamping.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] cur,
        input logic [SAT_W-1:0] step,
        input logic             up,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] sum;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            return (sum > {1'b0, max_val}) ? max_val : sum[SAT_W-1:0];
        end
        return (step > cur) ? '0 : (cur - step);
    endfunction

endpackage

// File: rtl/lever_chan.sv
// -----------------------------------------------------------------------------
// lever_chan
// One lever channel: D-pad ramp FSM with hold counter and acceleration, spring
// return toward REST_VAL, and the signed-stick analog mapper.
// Ports:
//   clk_sys, reset_l : clock and synchronous active-low reset
//   tick             : shared prescaler strobe, paces every ramp/return step
//   inc, dec         : D-pad levels for this channel
//   analog           : signed two's-complement stick value
//   mode             : source select (HOLD / SPRING / ANALOG, 3 = HOLD)
//   value            : registered lever value
//   at_min, at_max   : value == 0 / value == MAX_VAL
// -----------------------------------------------------------------------------
module lever_chan
    import lever_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_VAL     = 254,
    parameter int REST_VAL    = 0,
    parameter int ACCEL_TICKS = 32,
    parameter int FAST_STEP   = 4,
    parameter int INVERT      = 1
) (
    input  logic             clk_sys,
    input  logic             reset_l,
    input  logic             tick,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] analog,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] value,
    output logic             at_min,
    output logic             at_max
);

    // Counter wide enough to reach ACCEL_TICKS; it saturates so a long hold
    // with acceleration disabled never wraps back through the threshold.
    localparam int              HC_W   = $clog2(ACCEL_TICKS + 2);
    localparam logic [HC_W-1:0] HC_MAX = '1;
    localparam logic [HC_W-1:0] HC_ACC = HC_W'(ACCEL_TICKS);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESTV = WIDTH'(REST_VAL);
    // A fresh ramp already has hold count 1, so ACCEL_TICKS == 1 goes
    // straight to fast stepping.
    localparam state_e ENTRY_ST = (ACCEL_TICKS == 1) ? FAST : RAMP;

    function automatic logic [WIDTH-1:0] step_val(
        input logic [WIDTH-1:0] cur,
        input int               step,
        input logic             up
    );
        return WIDTH'(sat_step(SAT_W'(cur), SAT_W'(step), up, SAT_W'(MAX_VAL)));
    endfunction

    state_e          state;
    dir_e            last_dir;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_inc;
    dir_e            dir;
    logic            is_spring;
    logic            is_analog;
    logic            dir_up;
    state_e          settle_st;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] mapped;
    logic [WIDTH-1:0] toward;

    always_comb begin
        dir = DIR_NONE;
        if (inc && !dec)
            dir = DIR_UP;
        else if (dec && !inc)
            dir = DIR_DOWN;
    end

    assign dir_up    = (dir == DIR_UP);
    assign is_spring = (mode == SPRING);
    assign is_analog = (mode == ANALOG);
    assign hold_inc  = (hold_cnt == HC_MAX) ? hold_cnt : hold_cnt + HC_W'(1);

    // Where a released lever goes: spring mode keeps pulling unless already
    // at rest, everything else just stops.
    assign settle_st = (is_spring && value != RESTV) ? RETURN : IDLE;

    // Adding 2^(WIDTH-1) to a two's-complement value is an MSB flip.
    assign u      = {~analog[WIDTH-1], analog[WIDTH-2:0]};
    assign raw    = (INVERT != 0) ? ~u : u;
    assign mapped = (raw > MAXV) ? MAXV : raw;

    assign toward = (value > RESTV) ? step_val(value, 1, 1'b0)
                                    : step_val(value, 1, 1'b1);

    always_ff @(posedge clk_sys) begin
        if (!reset_l) begin
            state    <= IDLE;
            value    <= RESTV;
            hold_cnt <= '0;
            last_dir <= DIR_NONE;
        end else if (is_analog) begin
            // Stick tracks every cycle; the FSM is parked so that leaving
            // analog starts from a clean IDLE at the current value.
            value    <= mapped;
            state    <= IDLE;
            hold_cnt <= '0;
            last_dir <= DIR_NONE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (dir != DIR_NONE) begin
                        state    <= ENTRY_ST;
                        value    <= step_val(value, 1, dir_up);
                        hold_cnt <= HC_W'(1);
                        last_dir <= dir;
                    end else if (is_spring && value != RESTV) begin
                        state <= RETURN;
                    end
                end
                RAMP: begin
                    if (dir == DIR_NONE) begin
                        state    <= settle_st;
                        hold_cnt <= '0;
                        last_dir <= DIR_NONE;
                    end else if (dir != last_dir) begin
                        state    <= ENTRY_ST;
                        value    <= step_val(value, 1, dir_up);
                        hold_cnt <= HC_W'(1);
                        last_dir <= dir;
                    end else begin
                        value    <= step_val(value, 1, dir_up);
                        hold_cnt <= hold_inc;
                        if (ACCEL_TICKS != 0 && hold_inc == HC_ACC)
                            state <= FAST;
                    end
                end
                FAST: begin
                    if (dir == DIR_NONE) begin
                        state    <= settle_st;
                        hold_cnt <= '0;
                        last_dir <= DIR_NONE;
                    end else if (dir != last_dir) begin
                        state    <= ENTRY_ST;
                        value    <= step_val(value, 1, dir_up);
                        hold_cnt <= HC_W'(1);
                        last_dir <= dir;
                    end else begin
                        value <= step_val(value, FAST_STEP, dir_up);
                    end
                end
                RETURN: begin
                    if (dir != DIR_NONE) begin
                        state    <= ENTRY_ST;
                        value    <= step_val(value, 1, dir_up);
                        hold_cnt <= HC_W'(1);
                        last_dir <= dir;
                    end else if (!is_spring || value == RESTV) begin
                        state <= IDLE;
                    end else begin
                        value <= toward;
                        if (toward == RESTV)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign at_min = (value == '0);
    assign at_max = (value == MAXV);

endmodule

// File: rtl/lever_emu.sv
// -----------------------------------------------------------------------------
// lever_emu
// Multi-channel analog lever emulator between the joystick mux and the game
// core. A shared free-running prescaler paces every channel's ramp.
// Ports:
//   clk_sys, reset_l : clock and synchronous active-low reset
//   inc, dec         : per-channel D-pad levels (CHANNELS bits each)
//   analog           : per-channel signed stick values, WIDTH bits per channel
//   mode             : per-channel 2-bit source select
//   value            : per-channel lever value, WIDTH bits per channel
//   at_min, at_max   : per-channel limit flags
//   tick             : one-cycle prescaler strobe
// -----------------------------------------------------------------------------
module lever_emu
    import lever_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 196850,
    parameter int MAX_VAL     = 254,
    parameter int REST_VAL    = 0,
    parameter int ACCEL_TICKS = 32,
    parameter int FAST_STEP   = 4,
    parameter int INVERT      = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset_l,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS*WIDTH-1:0] analog,
    input  logic [CHANNELS*2-1:0]     mode,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       at_min,
    output logic [CHANNELS-1:0]       at_max,
    output logic                      tick
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;

    // tick is registered one count early so it is high exactly while the
    // counter sits at TICK_DIV-1; this is why TICK_DIV must be at least 2.
    always_ff @(posedge clk_sys) begin
        if (!reset_l) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            if (presc == PW'(TICK_DIV - 1))
                presc <= '0;
            else
                presc <= presc + PW'(1);
            tick <= (presc == PW'(TICK_DIV - 2));
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        lever_chan #(
            .WIDTH      (WIDTH),
            .MAX_VAL    (MAX_VAL),
            .REST_VAL   (REST_VAL),
            .ACCEL_TICKS(ACCEL_TICKS),
            .FAST_STEP  (FAST_STEP),
            .INVERT     (INVERT)
        ) u_chan (
            .clk_sys(clk_sys),
            .reset_l(reset_l),
            .tick   (tick),
            .inc    (inc[c]),
            .dec    (dec[c]),
            .analog (analog[c*WIDTH +: WIDTH]),
            .mode   (mode[c*2 +: 2]),
            .value  (value[c*WIDTH +: WIDTH]),
            .at_min (at_min[c]),
            .at_max (at_max[c])
        );
    end

endmodule

// File: tb/tb_lever_emu.sv
// -----------------------------------------------------------------------------
// tb_lever_emu
// Scoreboard bench for lever_emu with TICK_DIV=4, ACCEL_TICKS=3, FAST_STEP=4,
// MAX_VAL=254, REST_VAL=0, two 8-bit channels.
// -----------------------------------------------------------------------------
module tb_lever_emu;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int K_VAL = 0, K_MIN = 1, K_MAX = 2, K_TICK = 3;
    localparam logic [1:0] M_HOLD = 2'd0, M_SPRING = 2'd1, M_ANALOG = 2'd2;

    logic              clk_sys = 1'b0;
    logic              reset_l = 1'b0;
    logic [CH-1:0]     inc     = '0;
    logic [CH-1:0]     dec     = '0;
    logic [CH*W-1:0]   analog  = '0;
    logic [CH*2-1:0]   mode    = '0;
    logic [CH*W-1:0]   value;
    logic [CH-1:0]     at_min;
    logic [CH-1:0]     at_max;
    logic              tick;

    always #5 clk_sys = ~clk_sys;

    lever_emu #(
        .CHANNELS(CH), .WIDTH(W), .TICK_DIV(4), .MAX_VAL(254), .REST_VAL(0),
        .ACCEL_TICKS(3), .FAST_STEP(4), .INVERT(1)
    ) dut (
        .clk_sys(clk_sys), .reset_l(reset_l), .inc(inc), .dec(dec),
        .analog(analog), .mode(mode), .value(value), .at_min(at_min),
        .at_max(at_max), .tick(tick)
    );

    typedef struct {
        string tag;
        int    ch;
        int    kind;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int obs_of(input int ch, input int kind);
        case (kind)
            K_VAL:   return int'(value[ch*W +: W]);
            K_MIN:   return int'(at_min[ch]);
            K_MAX:   return int'(at_max[ch]);
            default: return int'(tick);
        endcase
    endfunction

    task automatic push(input string tag, input int ch, input int kind, input int exp);
        exp_t e;
        e.tag = tag; e.ch = ch; e.kind = kind; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs_of(e.ch, e.kind), e.exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk_sys);
        #1;
    endtask

    // Advance through the edge that closes the next tick cycle.
    task automatic next_tick();
        int n = 0;
        while (!tick && n < 16) begin
            edge1();
            n++;
        end
        if (!tick) chk("tick_timeout", 0, 1);
        edge1();
    endtask

    task automatic set_analog(input int ch, input int a);
        analog[ch*W +: W] = W'(a);
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[ch*2 +: 2] = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ramp_exp[5] = '{1, 2, 3, 7, 11};
        int top_exp[4]  = '{251, 252, 253, 254};
        int ret_exp[5]  = '{4, 3, 2, 1, 0};

        // Reset, then 20 idle cycles: tick on cycles 3, 7, 11, 15, 19
        reset_l = 1'b0;
        repeat (3) edge1();
        reset_l = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            push("idle_tick", 0, K_TICK, (cyc % 4 == 3) ? 1 : 0);
            push("idle_val", 0, K_VAL, 0);
            push("idle_min", 0, K_MIN, 1);
            drain();
            edge1();
        end

        // Hold mode ramp with acceleration, then release
        inc[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push("hold_ramp", 0, K_VAL, ramp_exp[i]);
            next_tick();
            drain();
        end
        inc[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("hold_keep", 0, K_VAL, 11);
            next_tick();
            drain();
        end

        // Load 250 via the stick, then ramp into the upper clamp
        set_analog(0, -123);
        set_mode(0, M_ANALOG);
        push("load_250", 0, K_VAL, 250);
        edge1();
        drain();
        set_mode(0, M_HOLD);
        inc[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push("top_ramp", 0, K_VAL, top_exp[i]);
            next_tick();
            drain();
        end
        push("top_atmax", 0, K_MAX, 1);
        push("top_hold", 0, K_VAL, 254);
        next_tick();
        drain();
        dec[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("both_val", 0, K_VAL, 254);
            push("both_atmax", 0, K_MAX, 1);
            next_tick();
            drain();
        end
        inc[0] = 1'b0;
        dec[0] = 1'b0;

        // Spring return: build value 5 in hold mode, then switch to spring
        set_analog(0, 127);
        set_mode(0, M_ANALOG);
        push("load_0", 0, K_VAL, 0);
        edge1();
        drain();
        set_mode(0, M_HOLD);
        inc[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("spr_up1", 0, K_VAL, i + 1);
            next_tick();
            drain();
        end
        inc[0] = 1'b0;
        push("spr_rel1", 0, K_VAL, 3);
        next_tick();
        drain();
        inc[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("spr_up2", 0, K_VAL, i + 4);
            next_tick();
            drain();
        end
        inc[0] = 1'b0;
        push("spr_rel2", 0, K_VAL, 5);
        next_tick();
        drain();
        set_mode(0, M_SPRING);
        push("spr_enter", 0, K_VAL, 5);
        next_tick();
        drain();
        for (int i = 0; i < 5; i++) begin
            push("spr_return", 0, K_VAL, ret_exp[i]);
            next_tick();
            drain();
        end
        push("spr_atmin", 0, K_MIN, 1);
        drain();
        dec[0] = 1'b1;
        push("spr_dec0", 0, K_VAL, 0);
        next_tick();
        drain();
        dec[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push("spr_rest", 0, K_VAL, 0);
            next_tick();
            drain();
        end

        // Analog mapping and bumpless exit to hold
        set_mode(0, M_ANALOG);
        set_analog(0, -128);
        push("ana_m128", 0, K_VAL, 254);
        edge1();
        drain();
        set_analog(0, 0);
        push("ana_0", 0, K_VAL, 127);
        edge1();
        drain();
        set_analog(0, 127);
        push("ana_127", 0, K_VAL, 0);
        edge1();
        drain();
        set_analog(0, 0);
        push("ana_back", 0, K_VAL, 127);
        edge1();
        drain();
        set_mode(0, M_HOLD);
        push("ana_keep", 0, K_VAL, 127);
        next_tick();
        drain();
        inc[0] = 1'b1;
        push("ana_inc", 0, K_VAL, 128);
        next_tick();
        drain();
        inc[0] = 1'b0;

        // Two channels, reset asserted mid-ramp
        set_analog(0, 127);
        set_analog(1, 117);
        set_mode(0, M_ANALOG);
        set_mode(1, M_ANALOG);
        push("two_load0", 0, K_VAL, 0);
        push("two_load1", 1, K_VAL, 10);
        edge1();
        drain();
        set_mode(0, M_HOLD);
        set_mode(1, M_SPRING);
        inc[0] = 1'b1;
        dec[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("two_ch0", 0, K_VAL, i + 1);
            push("two_ch1", 1, K_VAL, 9 - i);
            next_tick();
            drain();
        end
        edge1();
        reset_l = 1'b0;
        push("rst_ch0", 0, K_VAL, 0);
        push("rst_ch1", 1, K_VAL, 0);
        push("rst_min0", 0, K_MIN, 1);
        push("rst_min1", 1, K_MIN, 1);
        push("rst_tick", 0, K_TICK, 0);
        edge1();
        drain();
        reset_l = 1'b1;
        inc = '0;
        dec = '0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            push("rst_presc", 0, K_TICK, (cyc == 3) ? 1 : 0);
            drain();
            edge1();
        end
        push("post_ch0", 0, K_VAL, 0);
        push("post_ch1", 1, K_VAL, 0);
        next_tick();
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/lever_emu.md
Name: lever_emu

Overview:
- Multi-channel emulator for the cabinet's analog control levers (the Lunar Lander thrust lever and similar pot-driven inputs in later Atari vector cores).
- Each channel's value comes from one of three sources: D-pad ramp with hold, D-pad ramp with spring return, or a signed analog stick.
- Sits between the joystick mux and the game core input port.
- Generalises the single hold-only 8-bit thrust counter. Adds width, channel count, acceleration, spring return and bumpless mode switching.

Parameters:
- CHANNELS, 2, number of independent levers.
- WIDTH, 8, lever value width in bits.
- TICK_DIV, 196850, clk_sys cycles per ramp tick; must be >= 2.
- MAX_VAL, 254, upper clamp. Must be < 2^WIDTH. A DAC-limited board never sees all-ones.
- REST_VAL, 0, spring-return target. Must be <= MAX_VAL.
- ACCEL_TICKS, 32, consecutive held ticks before fast stepping; 0 disables acceleration.
- FAST_STEP, 4, step size in the FAST state; slow step is always 1.
- INVERT, 1, analog mapping direction. 1: stick full up gives 0.

Ports:
- clk_sys, in, 1, single clock.
- reset_l, in, 1, reset, synchronous, active-low.
- inc, in, CHANNELS, per-channel D-pad increase, level, active-high.
- dec, in, CHANNELS, per-channel D-pad decrease, level, active-high.
- analog, in, CHANNELS*WIDTH, per-channel signed two's-complement stick value.
- mode, in, CHANNELS*2, per-channel source select: 0 = hold, 1 = spring, 2 = analog, 3 = reserved (behaves as hold).
- value, out, CHANNELS*WIDTH, lever value to the core.
- at_min, out, CHANNELS, value == 0.
- at_max, out, CHANNELS, value == MAX_VAL.
- tick, out, 1, one-cycle prescaler strobe, exported for the bench and lamps.

Behaviour:
- Reset (reset_l low at a clock edge): prescaler = 0, tick = 0. Every channel goes to IDLE with value = REST_VAL and hold counter = 0. at_min/at_max follow value. Reset mid-ramp aborts immediately.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle the count equals TICK_DIV-1. It is shared by all channels and free-running, independent of the inputs.
- Per-channel direction: dir = inc & ~dec gives up; dec & ~inc gives down. Both or neither means none.
- Per-channel FSM, evaluated only on tick cycles except where noted:
  - IDLE: dir != none moves to RAMP and applies a step of 1 in the same tick. Hold counter = 1.
  - RAMP: the same dir steps by 1 and increments the hold counter. When the hold counter reaches ACCEL_TICKS (nonzero), go to FAST. A dir change restarts RAMP with the counter at 1. none goes to IDLE, or to RETURN in spring mode.
  - FAST: the same dir steps by FAST_STEP. Any change goes to IDLE, or to RETURN in spring mode. A reversal is treated as a fresh IDLE-to-RAMP entry.
  - RETURN (spring mode only): each tick moves value 1 toward REST_VAL, reaching IDLE at equality. Any dir != none leaves RETURN for RAMP.
- Step arithmetic:
  - Computed at WIDTH+1 bits, saturating to [0, MAX_VAL].
  - A step never wraps. Example: 252 + 4 gives 254; 2 - 4 gives 0.
  - Holding at a limit keeps the FSM state but leaves value unchanged.
- Analog mode:
  - value updates every cycle, registered, with 1-cycle latency; the FSM is forced to IDLE.
  - Mapping: u = analog + 2^(WIDTH-1), taken as unsigned.
  - INVERT=1: raw = (2^WIDTH - 1) - u. INVERT=0: raw = u.
  - value = min(raw, MAX_VAL).
  - Example (W=8, INVERT=1): analog -128 gives 254 after clamp; 127 gives 0; 0 gives 127.
- Mode change:
  - Takes effect on the next cycle. value is kept, so leaving analog is bumpless.
  - Entering spring with value != REST_VAL and dir = none goes to RETURN at the next tick.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Package lever_pkg holds:
  - mode_e typedef: HOLD=0, SPRING=1, ANALOG=2.
  - state_e typedef: IDLE, RAMP, FAST, RETURN.
  - a saturating add/sub function, parameterised by WIDTH and MAX_VAL.
- Sub-module lever_chan holds one channel's FSM, hold counter and analog mapper. Top lever_emu holds the prescaler and a generate loop over CHANNELS.

Test Plan:
- Every test below uses TICK_DIV=4, ACCEL_TICKS=3, FAST_STEP=4, MAX_VAL=254, REST_VAL=0.
- Reset then idle 20 cycles: value=0, at_min=1, and tick pulses on cycles 3, 7, 11, 15, 19.
- Hold mode, inc held for 5 ticks: value reads 1, 2, 3 at ticks 1-3, then 7 and 11. Release: value stays 11 indefinitely.
- Hold mode, inc held from value 250: value becomes 254 with at_max=1. Further ticks keep 254. inc+dec together: no change.
- Spring mode: ramp to 5, release, and value steps 4, 3, 2, 1, 0 on successive ticks, then IDLE. Pressing dec at 0 leaves value at 0.
- Analog mode, analog = -128 / 0 / 127: value = 254 / 127 / 0 one cycle later. Switch to hold at 127: value holds 127, and one inc tick gives 128.
- Two channels: ch0 inc and ch1 dec in spring mode from 10, with reset_l low mid-ramp. Both channels show 0 and IDLE on the next edge, and the prescaler restarts at 0.
